// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants; the decode stage reuses if_id_t.
// No logic here, so no latency of its own.
// No backpressure: constants and types only.
package fetch_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 64;
  localparam int CNT_W   = 16;

  localparam logic [PC_W-1:0]  RESET_PC  = '0;
  localparam logic [PC_W-1:0]  LAST_PC   = PC_W'(DEPTH - 1);
  // One extra bit so that DEPTH itself is representable, even when DEPTH == 2^PC_W.
  localparam logic [PC_W:0]    DEPTH_LIM = (PC_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus1;
  } if_id_t;

  // Word-index increment. It wraps in PC_W bits, which is harmless because DEPTH <= 2^PC_W.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Bus between the fetch stage, the instruction memory and the decode/branch logic.
// Signals are combinational wires, so the bus adds no latency.
// The stall and redirect inputs are the only flow control; the memory is always ready.
interface fetch_if;
  import fetch_pkg::*;

  logic [PC_W-1:0]    imem_pc;
  logic [INSTR_W-1:0] imem_instruction;
  logic               stall;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               if_id_valid;
  logic [INSTR_W-1:0] if_id_instr;
  logic [PC_W-1:0]    if_id_pc;
  logic [PC_W-1:0]    if_id_pc_plus1;
  logic               halted;
  logic               bad_target;
  logic [CNT_W-1:0]   fetch_count;

  // The fetch unit owns the PC and the IF/ID outputs.
  modport master (
    output imem_pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1,
           halted, bad_target, fetch_count,
    input  imem_instruction, stall, redirect_valid, redirect_pc
  );

  // Environment side: the memory model plus the downstream hazard and branch logic.
  modport slave (
    input  imem_pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus1,
           halted, bad_target, fetch_count,
    output imem_instruction, stall, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with load, hold and clear (valid-only) control.
// Latency: one cycle from din to dout on a load.
// Backpressure: when neither load nor clear is asserted the register holds (stall).
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  logic   clear,
  input  if_id_t din,
  output if_id_t dout
);

  if_id_t r_q, r_d;

  // Load has priority. Clear only drops valid, so the payload of a killed slot stays readable.
  always_comb begin
    r_d = r_q;
    if (load) begin
      r_d = din;
    end else if (clear) begin
      r_d.valid = 1'b0;
    end
  end

  // Register state; reset is asynchronous and zeroes every field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign dout = r_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, indexes the memory and fills IF/ID. Handles redirects and end-of-program halt.
// Latency: the word at index k appears on if_id_instr one cycle after imem_pc == k; throughput is 1 per cycle.
// Backpressure: stall holds the PC and IF/ID; a redirect overrides stall and kills the IF/ID slot.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  fetch_if.master  bus
);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             bad_target_q, bad_target_d;
  logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

  logic   ifid_load;
  logic   ifid_clear;
  logic   target_ok;
  if_id_t ifid_din;
  if_id_t ifid_q;

  assign target_ok = ({1'b0, bus.redirect_pc} < DEPTH_LIM);
  assign ifid_din  = '{valid: 1'b1, instr: bus.imem_instruction, pc: pc_q, pc_plus1: pc_inc(pc_q)};

  // Next state, next PC, IF/ID control and the delivered-instruction counter.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    bad_target_d  = bad_target_q;
    fetch_count_d = fetch_count_q;
    ifid_load     = 1'b0;
    ifid_clear    = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.redirect_valid) begin
          // The slot in IF/ID is on the wrong path, whatever decode is doing.
          ifid_clear = 1'b1;
          if (target_ok) begin
            pc_d = bus.redirect_pc;
          end else begin
            bad_target_d = 1'b1;
            state_d      = HALT;
          end
        end else if (!bus.stall) begin
          ifid_load = 1'b1;
          if (fetch_count_q != CNT_MAX) begin
            fetch_count_d = fetch_count_q + CNT_W'(1);
          end
          if (pc_q == LAST_PC) begin
            state_d = HALT;
          end else begin
            pc_d = pc_inc(pc_q);
          end
        end
      end
      HALT: begin
        if (bus.redirect_valid) begin
          ifid_clear = 1'b1;
          if (target_ok) begin
            pc_d    = bus.redirect_pc;
            state_d = RUN;
          end else begin
            bad_target_d = 1'b1;
          end
        end else if (!bus.stall) begin
          // Decode has taken the final instruction, so the slot empties.
          ifid_clear = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State, PC, sticky error and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      bad_target_q  <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      bad_target_q  <= bad_target_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ifid_load),
    .clear (ifid_clear),
    .din   (ifid_din),
    .dout  (ifid_q)
  );

  assign bus.imem_pc        = pc_q;
  assign bus.if_id_valid    = ifid_q.valid;
  assign bus.if_id_instr    = ifid_q.instr;
  assign bus.if_id_pc       = ifid_q.pc;
  assign bus.if_id_pc_plus1 = ifid_q.pc_plus1;
  assign bus.halted         = (state_q == HALT);
  assign bus.bad_target     = bad_target_q;
  assign bus.fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios, then randomized traffic against a reference model.
// Inputs change 1ns after the rising edge, and outputs are sampled at that same point.
// The memory is a bench array read combinationally at imem_pc.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  fetch_if bus();

  logic [31:0] mem [0:255];
  int n_pass;
  int n_total;

  // Reference model state, written from the behavioural rules of the fetch stage.
  logic [7:0]  m_pc;
  bit          m_halt;
  bit          m_bad;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [7:0]  m_ipc;
  int          m_cnt;

  assign bus.imem_instruction = mem[bus.imem_pc];

  fetch_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    m_pc = 8'd0; m_halt = 0; m_bad = 0; m_valid = 0;
    m_instr = '0; m_ipc = 8'd0; m_cnt = 0;
  endtask

  task automatic idle_inputs();
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 8'd0;
  endtask

  // Advance one clock with the current inputs and update the model alongside.
  task automatic tick();
    logic [7:0]  n_pc    = m_pc;
    bit          n_halt  = m_halt;
    bit          n_bad   = m_bad;
    bit          n_valid = m_valid;
    logic [31:0] n_instr = m_instr;
    logic [7:0]  n_ipc   = m_ipc;
    int          n_cnt   = m_cnt;
    if (bus.redirect_valid) begin
      n_valid = 0;
      if (int'(bus.redirect_pc) < 64) begin
        n_pc = bus.redirect_pc;
        n_halt = 0;
      end else begin
        n_bad = 1;
        n_halt = 1;
      end
    end else if (m_halt) begin
      if (!bus.stall) n_valid = 0;
    end else if (!bus.stall) begin
      n_valid = 1;
      n_instr = mem[m_pc];
      n_ipc = m_pc;
      n_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      if (m_pc == 8'd63) n_halt = 1;
      else n_pc = m_pc + 8'd1;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_halt = n_halt; m_bad = n_bad; m_valid = n_valid;
    m_instr = n_instr; m_ipc = n_ipc; m_cnt = n_cnt;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    logic [76:0] got;
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    got = {bus.imem_pc, bus.if_id_valid, bus.if_id_instr, bus.if_id_pc, bus.if_id_pc_plus1,
           bus.halted, bus.bad_target, bus.fetch_count};
    n_total++;
    if (got !== 77'd0) $display("FAIL reset_values: got %h exp 0", got);
    else n_pass++;
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_sequence();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (bus.imem_pc !== 8'(k)) $display("FAIL seq_pc%0d: got %h exp %h", k, bus.imem_pc, 8'(k));
      else n_pass++;
      tick();
      n_total++;
      if ({bus.if_id_valid, bus.if_id_instr, bus.if_id_pc} !== {1'b1, 32'(32'h11 + k), 8'(k)})
        $display("FAIL seq_ifid%0d: got v=%b i=%h pc=%h exp v=1 i=%h pc=%h", k,
                 bus.if_id_valid, bus.if_id_instr, bus.if_id_pc, 32'(32'h11 + k), 8'(k));
      else n_pass++;
    end
    n_total++;
    if (bus.fetch_count !== 16'd4) $display("FAIL seq_count: got %0d exp 4", bus.fetch_count);
    else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    tick();
    tick();
    bus.stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_total++;
      if ({bus.imem_pc, bus.if_id_valid, bus.if_id_instr} !== {8'd2, 1'b1, 32'h12})
        $display("FAIL stall_hold%0d: got pc=%h v=%b i=%h exp pc=02 v=1 i=00000012", c,
                 bus.imem_pc, bus.if_id_valid, bus.if_id_instr);
      else n_pass++;
    end
    bus.stall = 1'b0;
    tick();
    n_total++;
    if ({bus.if_id_instr, bus.imem_pc} !== {32'h13, 8'd3})
      $display("FAIL stall_resume: got i=%h pc=%h exp i=00000013 pc=03", bus.if_id_instr, bus.imem_pc);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.if_id_instr, bus.fetch_count} !== {32'h14, 16'd4})
      $display("FAIL stall_nodup: got i=%h cnt=%0d exp i=00000014 cnt=4", bus.if_id_instr, bus.fetch_count);
    else n_pass++;
  endtask

  task automatic test_redirect();
    do_reset();
    for (int c = 0; c < 5; c++) tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'h20;
    tick();
    idle_inputs();
    n_total++;
    if ({bus.if_id_valid, bus.imem_pc} !== {1'b0, 8'h20})
      $display("FAIL redir_kill: got v=%b pc=%h exp v=0 pc=20", bus.if_id_valid, bus.imem_pc);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.if_id_valid, bus.if_id_pc, bus.if_id_pc_plus1, bus.if_id_instr} !== {1'b1, 8'h20, 8'h21, 32'h31})
      $display("FAIL redir_target: got v=%b pc=%h pc1=%h i=%h exp v=1 pc=20 pc1=21 i=00000031",
               bus.if_id_valid, bus.if_id_pc, bus.if_id_pc_plus1, bus.if_id_instr);
    else n_pass++;
  endtask

  task automatic test_redirect_stall();
    bus.stall = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'd7;
    tick();
    idle_inputs();
    n_total++;
    if ({bus.imem_pc, bus.if_id_valid} !== {8'd7, 1'b0})
      $display("FAIL redir_stall: got pc=%h v=%b exp pc=07 v=0", bus.imem_pc, bus.if_id_valid);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.if_id_valid, bus.if_id_pc} !== {1'b1, 8'd7})
      $display("FAIL redir_stall_fetch: got v=%b pc=%h exp v=1 pc=07", bus.if_id_valid, bus.if_id_pc);
    else n_pass++;
  endtask

  task automatic test_end_of_program();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'd60;
    tick();
    idle_inputs();
    for (int c = 0; c < 4; c++) tick();
    n_total++;
    if ({bus.if_id_valid, bus.if_id_pc, bus.halted, bus.imem_pc} !== {1'b1, 8'd63, 1'b1, 8'd63})
      $display("FAIL eop_last: got v=%b pc=%h h=%b ipc=%h exp v=1 pc=3f h=1 ipc=3f",
               bus.if_id_valid, bus.if_id_pc, bus.halted, bus.imem_pc);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.if_id_valid, bus.halted, bus.imem_pc} !== {1'b0, 1'b1, 8'd63})
      $display("FAIL eop_drain: got v=%b h=%b ipc=%h exp v=0 h=1 ipc=3f", bus.if_id_valid, bus.halted, bus.imem_pc);
    else n_pass++;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'd0;
    tick();
    idle_inputs();
    n_total++;
    if ({bus.halted, bus.imem_pc} !== {1'b0, 8'd0})
      $display("FAIL eop_resume: got h=%b ipc=%h exp h=0 ipc=00", bus.halted, bus.imem_pc);
    else n_pass++;
    tick();
    n_total++;
    if ({bus.if_id_valid, bus.if_id_pc, bus.if_id_instr} !== {1'b1, 8'd0, 32'h11})
      $display("FAIL eop_refetch: got v=%b pc=%h i=%h exp v=1 pc=00 i=00000011",
               bus.if_id_valid, bus.if_id_pc, bus.if_id_instr);
    else n_pass++;
  endtask

  task automatic test_bad_target_reset();
    logic [76:0] got;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 8'h40;
    tick();
    idle_inputs();
    n_total++;
    if ({bus.bad_target, bus.halted, bus.if_id_valid} !== 3'b110)
      $display("FAIL bad_target: got bad=%b h=%b v=%b exp bad=1 h=1 v=0", bus.bad_target, bus.halted, bus.if_id_valid);
    else n_pass++;
    rst_n = 1'b0;
    #2;
    got = {bus.imem_pc, bus.if_id_valid, bus.if_id_instr, bus.if_id_pc, bus.if_id_pc_plus1,
           bus.halted, bus.bad_target, bus.fetch_count};
    n_total++;
    if (got !== 77'd0) $display("FAIL async_reset: got %h exp 0", got);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_clear();
    tick();
    n_total++;
    if ({bus.if_id_valid, bus.if_id_pc, bus.bad_target} !== {1'b1, 8'd0, 1'b0})
      $display("FAIL post_reset_fetch: got v=%b pc=%h bad=%b exp v=1 pc=00 bad=0",
               bus.if_id_valid, bus.if_id_pc, bus.bad_target);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [27:0] got, exp;
    logic [47:0] gpay, epay;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if (c == 400) do_reset();
      bus.stall = ($urandom_range(3) == 0);
      bus.redirect_valid = ($urandom_range(11) == 0);
      bus.redirect_pc = ($urandom_range(9) == 0) ? 8'($urandom_range(255, 64)) : 8'($urandom_range(63));
      tick();
      got = {bus.imem_pc, bus.if_id_valid, bus.halted, bus.bad_target, bus.fetch_count};
      exp = {m_pc, m_valid, m_halt, m_bad, 16'(m_cnt)};
      n_total++;
      if (got !== exp) $display("FAIL rand_state c=%0d: got %h exp %h", c, got, exp);
      else n_pass++;
      if (m_valid) begin
        gpay = {bus.if_id_instr, bus.if_id_pc, bus.if_id_pc_plus1};
        epay = {m_instr, m_ipc, 8'(m_ipc + 8'd1)};
        n_total++;
        if (gpay !== epay) $display("FAIL rand_ifid c=%0d: got %h exp %h", c, gpay, epay);
        else n_pass++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    idle_inputs();
    model_clear();
    for (int i = 0; i < 256; i++) mem[i] = 32'(32'h11 + i);
    test_reset();
    test_sequence();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_end_of_program();
    test_bad_target_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
